// File: rtl/key_cond_pkg.sv
// Shared types, default timing constants and counter sizing for the key conditioner.
// Latency: n/a (package). Backpressure: n/a.
package key_cond_pkg;

    typedef enum logic [1:0] {REL, HOLD, RPT} key_state_t;

    localparam int DEBOUNCE_CYC_DEF = 50_000;
    localparam int PULSE_CYC_DEF    = 4096;
    localparam int REPEAT_DLY_DEF   = 25_000_000;
    localparam int REPEAT_RATE_DEF  = 5_000_000;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_chan.sv
// One push-button channel: 2-flop sync, debounce, press FSM (auto-repeat under KEY_AUTOREPEAT_EN), pulse stretcher.
// Latency: output rises DEBOUNCE_CYC+3 edges after a steady raw press. Backpressure: none, free-running level output.
module key_chan
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int PULSE_CYC    = PULSE_CYC_DEF
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DLY   = REPEAT_DLY_DEF,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEF
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_evt_lvl
);

    localparam int DCNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int PCNT_W = $clog2(PULSE_CYC + 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              w_pressed_s;
    logic              r_stable;
    logic [DCNT_W-1:0] r_dcnt;
    key_state_t        r_state;
    logic              r_evt;
    logic [PCNT_W-1:0] r_pcnt;
    logic [PCNT_W-1:0] w_pcnt_nxt;
    logic              r_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed_s = ~r_sync2;

    // A new level is accepted only after DEBOUNCE_CYC consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= 1'b0;
            r_dcnt   <= '0;
        end else if (w_pressed_s == r_stable) begin
            r_dcnt <= '0;
        end else if (r_dcnt == DCNT_W'(DEBOUNCE_CYC - 1)) begin
            r_stable <= w_pressed_s;
            r_dcnt   <= '0;
        end else begin
            r_dcnt <= r_dcnt + DCNT_W'(1);
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int RCNT_W  = cnt_w(RPT_MAX);

    logic [RCNT_W-1:0] r_rcnt;

    // Release wins over a repeat landing on the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= REL;
            r_evt   <= 1'b0;
            r_rcnt  <= '0;
        end else begin
            r_evt <= 1'b0;
            if (!r_stable) begin
                r_state <= REL;
                r_rcnt  <= '0;
            end else begin
                case (r_state)
                    REL: begin
                        r_evt   <= 1'b1;
                        r_rcnt  <= '0;
                        r_state <= HOLD;
                    end
                    HOLD: begin
                        if (r_rcnt == RCNT_W'(REPEAT_DLY - 1)) begin
                            r_evt   <= 1'b1;
                            r_rcnt  <= '0;
                            r_state <= RPT;
                        end else begin
                            r_rcnt <= r_rcnt + RCNT_W'(1);
                        end
                    end
                    RPT: begin
                        if (r_rcnt == RCNT_W'(REPEAT_RATE - 1)) begin
                            r_evt  <= 1'b1;
                            r_rcnt <= '0;
                        end else begin
                            r_rcnt <= r_rcnt + RCNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= REL;
                        r_rcnt  <= '0;
                    end
                endcase
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= REL;
            r_evt   <= 1'b0;
        end else begin
            r_evt <= 1'b0;
            if (!r_stable) begin
                r_state <= REL;
            end else if (r_state == REL) begin
                r_evt   <= 1'b1;
                r_state <= HOLD;
            end else begin
                r_state <= HOLD;
            end
        end
    end
`endif

    always_comb begin
        w_pcnt_nxt = r_pcnt;
        if (r_evt) begin
            w_pcnt_nxt = PCNT_W'(PULSE_CYC);
        end else if (r_pcnt != '0) begin
            w_pcnt_nxt = r_pcnt - PCNT_W'(1);
        end
    end

    // Output registered from the next count so it rises with the load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= '0;
            r_out  <= 1'b0;
        end else begin
            r_pcnt <= w_pcnt_nxt;
            r_out  <= (w_pcnt_nxt != '0);
        end
    end

    assign o_evt_lvl = r_out;

endmodule

// File: rtl/key_cond.sv
// Two independent push-button conditioners producing KEY_UP / KEY_DOWN stretched press levels; auto-repeat under KEY_AUTOREPEAT_EN.
// Latency: DEBOUNCE_CYC+3 edges from steady raw press to output rise. Backpressure: none.
module key_cond
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int PULSE_CYC    = PULSE_CYC_DEF,
    parameter int REPEAT_DLY   = REPEAT_DLY_DEF,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_up_n,
    input  logic key_down_n,
    output logic KEY_UP,
    output logic KEY_DOWN
);

    // A repeat interval no longer than the pulse would merge repeats into one level.
    if (DEBOUNCE_CYC < 1 || PULSE_CYC < 1 || REPEAT_DLY < 1 || REPEAT_RATE <= PULSE_CYC) begin : g_bad_cfg
        $error("key_cond: invalid timing parameters");
    end

    key_chan #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .PULSE_CYC    (PULSE_CYC)
`ifdef KEY_AUTOREPEAT_EN
        ,
        .REPEAT_DLY   (REPEAT_DLY),
        .REPEAT_RATE  (REPEAT_RATE)
`endif
    ) u_up (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_key_n   (key_up_n),
        .o_evt_lvl (KEY_UP)
    );

    key_chan #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .PULSE_CYC    (PULSE_CYC)
`ifdef KEY_AUTOREPEAT_EN
        ,
        .REPEAT_DLY   (REPEAT_DLY),
        .REPEAT_RATE  (REPEAT_RATE)
`endif
    ) u_down (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_key_n   (key_down_n),
        .o_evt_lvl (KEY_DOWN)
    );

endmodule

// File: tb/tb_key_cond.sv
// Directed bench for key_cond: debounce, single press, auto-repeat, dual keys, async reset.
module tb_key_cond;

    logic clk;
    logic rst_n;
    logic key_up_n;
    logic key_down_n;
    logic KEY_UP;
    logic KEY_DOWN;

    int n_chk  = 0;
    int n_pass = 0;

    key_cond #(
        .DEBOUNCE_CYC (4),
        .PULSE_CYC    (2),
        .REPEAT_DLY   (20),
        .REPEAT_RATE  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_up_n   (key_up_n),
        .key_down_n (key_down_n),
        .KEY_UP     (KEY_UP),
        .KEY_DOWN   (KEY_DOWN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [127:0] p2(input int a);
        logic [127:0] v;
        v = '0;
        v[a]   = 1'b1;
        v[a+1] = 1'b1;
        return v;
    endfunction

    function automatic logic [127:0] ones(input int n);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Called just after a rising edge; releases reset 1 time unit after a later edge.
    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Pattern bit i = 1 means the key is pressed when sampled at relative edge i.
    task automatic scen(input logic [127:0] up_pat, input logic [127:0] dn_pat, input int len,
                        output logic [127:0] up_v, output logic [127:0] dn_v);
        up_v = '0;
        dn_v = '0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            key_up_n   = ~up_pat[i];
            key_down_n = ~dn_pat[i];
            @(posedge clk);
            #1;
            up_v[i] = KEY_UP;
            dn_v[i] = KEY_DOWN;
        end
    endtask

    logic [127:0] uv, dv, pat, exp_rpt, exp_mid;

    initial begin
        rst_n      = 1'b0;
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        #12;

        // Reset held with the up key pressed, then a fresh debounced press.
        key_up_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_up", {127'd0, KEY_UP}, 128'd0);
        check("reset_down", {127'd0, KEY_DOWN}, 128'd0);
        rst_n = 1'b1;
        scen(ones(12), '0, 20, uv, dv);
        check("post_reset_up", uv, p2(7));
        check("post_reset_down", dv, '0);

        // Bounce: 3 low, 1 high, 3 low, then released.
        key_up_n = 1'b1; key_down_n = 1'b1;
        do_reset();
        pat = 128'h77;
        scen(pat, '0, 24, uv, dv);
        check("bounce_up", uv, '0);
        check("bounce_down", dv, '0);

        // Single 12-cycle press.
        key_up_n = 1'b1; key_down_n = 1'b1;
        do_reset();
        scen(ones(12), '0, 30, uv, dv);
        check("single_up", uv, p2(7));
        check("single_down", dv, '0);

        // Down held 60 cycles; the repeat due at edge 67 collides with release and is dropped.
        key_up_n = 1'b1; key_down_n = 1'b1;
        do_reset();
        scen('0, ones(60), 80, uv, dv);
`ifdef KEY_AUTOREPEAT_EN
        exp_rpt = p2(7) | p2(27) | p2(35) | p2(43) | p2(51) | p2(59);
`else
        exp_rpt = p2(7);
`endif
        check("repeat_down", dv, exp_rpt);
        check("repeat_up_idle", uv, '0);

        // Both keys together for 10 cycles.
        key_up_n = 1'b1; key_down_n = 1'b1;
        do_reset();
        scen(ones(10), ones(10), 24, uv, dv);
        check("simul_up", uv, p2(7));
        check("simul_down", dv, p2(7));

        // Reset after edge 30 while holding down, released before edge 32.
        key_up_n = 1'b1; key_down_n = 1'b1;
        do_reset();
        scen('0, ones(31), 31, uv, dv);
`ifdef KEY_AUTOREPEAT_EN
        exp_mid = p2(7) | p2(27);
`else
        exp_mid = p2(7);
`endif
        check("midrpt_pre", dv, exp_mid);
        #1 rst_n = 1'b0;
        #1 check("midrpt_in_reset", {127'd0, KEY_DOWN}, 128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        scen('0, ones(20), 20, uv, dv);
        check("midrpt_post", dv, p2(7));

        // Asynchronous reset in the middle of a pulse.
        key_up_n = 1'b1; key_down_n = 1'b1;
        do_reset();
        scen(ones(8), '0, 8, uv, dv);
        check("midpulse_high", uv, 128'h80);
        #1 rst_n = 1'b0;
        #1 check("midpulse_async_drop", {127'd0, KEY_UP}, 128'd0);
        key_up_n = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        scen('0, '0, 4, uv, dv);
        check("midpulse_after", uv, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
